// File: rtl/rv_wb_stage_pkg.sv
// Shared definitions for the RVX writeback stage: bus width, load funct3 codes,
// the zero register and the write-slot source encoding.
package rv_wb_stage_pkg;

  localparam int BUS_W = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Which producer owns the single regfile write slot this cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_MDU  = 2'd2
  } wb_src_e;

endpackage

// File: rtl/rv_wb_fifo.sv
// Small synchronous FIFO buffering out-of-order MDU results as {rd, data}.
// DEPTH must be a power of two so the pointers wrap naturally.
module rv_wb_fifo
  import rv_wb_stage_pkg::*;
#(
  parameter int DW    = 37,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DW-1:0]                wdata,
  input  logic                         pop,
  output logic [DW-1:0]                rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head is read combinationally so a pop can land in the writeback register.
  assign rdata = mem_q[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/rv_wb_stage.sv
// RVX writeback stage: merges in-order MEM results with buffered MDU results
// into one registered regfile write port. Optional RVX_WB_RETIRE_CNT_EN adds retire_cnt.
module rv_wb_stage
  import rv_wb_stage_pkg::*;
#(
  parameter int XLEN       = BUS_W,
  parameter int MDU_FIFO_D = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [4:0]      mem_rd,
  input  logic            mem_rd_we,
  input  logic            mem_is_load,
  input  logic [2:0]      mem_funct3,
  input  logic [1:0]      mem_addr_lo,
  input  logic [XLEN-1:0] mem_result,
  input  logic [XLEN-1:0] mem_load_raw,
  input  logic            mdu_valid,
  output logic            mdu_ready,
  input  logic [4:0]      mdu_rd,
  input  logic [XLEN-1:0] mdu_result,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata
`ifdef RVX_WB_RETIRE_CNT_EN
  ,
  output logic [63:0]     retire_cnt
`endif
);

  localparam int DW = 5 + XLEN;
  localparam int CW = $clog2(MDU_FIFO_D + 1);

  // Select byte/half lane from the aligned word, then sign- or zero-extend.
  function automatic logic [XLEN-1:0] fmt_load(
    input logic [2:0]      f3,
    input logic [1:0]      lo,
    input logic [XLEN-1:0] raw
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = raw[{lo, 3'b000} +: 8];
    h = raw[{lo[1], 4'b0000} +: 16];
    case (f3)
      F3_LB:   fmt_load = {{(XLEN-8){b[7]}}, b};
      F3_LH:   fmt_load = {{(XLEN-16){h[15]}}, h};
      F3_LW:   fmt_load = raw;
      F3_LBU:  fmt_load = {{(XLEN-8){1'b0}}, b};
      F3_LHU:  fmt_load = {{(XLEN-16){1'b0}}, h};
      default: fmt_load = raw;
    endcase
  endfunction

  logic            fifo_push;
  logic            fifo_pop;
  logic [DW-1:0]   fifo_rdata;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [4:0]      fifo_rd;
  logic [XLEN-1:0] fifo_data;

  logic            mem_fire;
  wb_src_e         src;
  logic            win_we;
  logic [4:0]      win_rd;
  logic [XLEN-1:0] win_data;
  logic            wr_next;

  logic            rf_we_reg;
  logic [4:0]      rf_waddr_reg;
  logic [XLEN-1:0] rf_wdata_reg;

  // Both producers stall only when the buffer is full; MEM stalls so the head can drain.
  assign mdu_ready = (fifo_count != CW'(MDU_FIFO_D));
  assign mem_ready = !fifo_full;
  assign mem_fire  = mem_valid && mem_ready;
  assign fifo_push = mdu_valid && mdu_ready;

  rv_wb_fifo #(
    .DW    (DW),
    .DEPTH (MDU_FIFO_D)
  ) u_mdu_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({mdu_rd, mdu_result}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign fifo_rd   = fifo_rdata[DW-1 -: 5];
  assign fifo_data = fifo_rdata[XLEN-1:0];

  // MEM has priority; the FIFO head only takes slots MEM leaves unused.
  always_comb begin
    src = SRC_NONE;
    if (mem_fire) begin
      src = SRC_MEM;
    end else if (!fifo_empty) begin
      src = SRC_MDU;
    end
  end

  assign fifo_pop = (src == SRC_MDU);

  always_comb begin
    win_we   = 1'b0;
    win_rd   = REG_ZERO;
    win_data = '0;
    case (src)
      SRC_MEM: begin
        win_we   = mem_rd_we;
        win_rd   = mem_rd;
        win_data = mem_is_load ? fmt_load(mem_funct3, mem_addr_lo, mem_load_raw)
                               : mem_result;
      end
      SRC_MDU: begin
        win_we   = 1'b1;
        win_rd   = fifo_rd;
        win_data = fifo_data;
      end
      default: begin
        win_we = 1'b0;
      end
    endcase
  end

  assign wr_next = win_we && (win_rd != REG_ZERO);

  // Address/data only move on a real write so they hold between writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we_reg    <= 1'b0;
      rf_waddr_reg <= REG_ZERO;
      rf_wdata_reg <= '0;
    end else begin
      rf_we_reg <= wr_next;
      if (wr_next) begin
        rf_waddr_reg <= win_rd;
        rf_wdata_reg <= win_data;
      end
    end
  end

  assign rf_we    = rf_we_reg;
  assign rf_waddr = rf_waddr_reg;
  assign rf_wdata = rf_wdata_reg;

`ifdef RVX_WB_RETIRE_CNT_EN
  // Counts every MEM handshake, including rd=0 and non-writing instructions.
  logic [63:0] retire_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_cnt_reg <= 64'd0;
    end else if (mem_fire) begin
      retire_cnt_reg <= retire_cnt_reg + 64'd1;
    end
  end

  assign retire_cnt = retire_cnt_reg;
`endif

endmodule

// File: tb/tb_rv_wb_stage.sv
// Directed testbench for rv_wb_stage: reset, load formatting, MEM/MDU arbitration,
// rd=0 suppression and the idle MDU path. Retire checks follow RVX_WB_RETIRE_CNT_EN.
`timescale 1ns/1ps
module tb_rv_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic        mem_rd_we;
  logic        mem_is_load;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_result;
  logic [31:0] mem_load_raw;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_result;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
`ifdef RVX_WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_retire = 64'd0;

  // Load vectors on raw word 0x80FF_7F01 (bytes 01,7F,FF,80 from lane 0 up).
  logic [2:0]  ld_f3  [8] = '{3'b000, 3'b101, 3'b001, 3'b100, 3'b000, 3'b010, 3'b011, 3'b001};
  logic [1:0]  ld_lo  [8] = '{2'd3,   2'd2,   2'd2,   2'd0,   2'd1,   2'd0,   2'd1,   2'd3};
  logic [31:0] ld_exp [8] = '{32'hFFFF_FF80, 32'h0000_80FF, 32'hFFFF_80FF, 32'h0000_0001,
                              32'h0000_007F, 32'h80FF_7F01, 32'h80FF_7F01, 32'hFFFF_80FF};

  // Hand-traced per-cycle writes for MEM every cycle plus three MDU pushes; 0 = no write.
  logic [4:0]  bb_addr [10] = '{5'd10, 5'd11, 5'd5, 5'd12, 5'd6, 5'd13, 5'd14, 5'd15, 5'd7, 5'd0};
  logic [31:0] bb_data [10] = '{32'h100, 32'h101, 32'hA00, 32'h102, 32'hA01,
                                32'h103, 32'h104, 32'h105, 32'hA02, 32'h0};

  always #5 clk = ~clk;

  rv_wb_stage dut (
    .clk          (clk),
    .rst          (rst),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_rd       (mem_rd),
    .mem_rd_we    (mem_rd_we),
    .mem_is_load  (mem_is_load),
    .mem_funct3   (mem_funct3),
    .mem_addr_lo  (mem_addr_lo),
    .mem_result   (mem_result),
    .mem_load_raw (mem_load_raw),
    .mdu_valid    (mdu_valid),
    .mdu_ready    (mdu_ready),
    .mdu_rd       (mdu_rd),
    .mdu_result   (mdu_result),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata)
`ifdef RVX_WB_RETIRE_CNT_EN
    ,
    .retire_cnt   (retire_cnt)
`endif
  );

  task automatic set_idle;
    mem_valid    = 1'b0;
    mem_rd       = 5'd0;
    mem_rd_we    = 1'b0;
    mem_is_load  = 1'b0;
    mem_funct3   = 3'b000;
    mem_addr_lo  = 2'd0;
    mem_result   = 32'h0;
    mem_load_raw = 32'h0;
    mdu_valid    = 1'b0;
    mdu_rd       = 5'd0;
    mdu_result   = 32'h0;
  endtask

  task automatic test_reset;
    set_idle();
    rst = 1'b0;
    #1;
    n_checks++; if (rf_we !== 1'b0) begin n_errors++; $display("FAIL reset_init_we: got %b expected 0", rf_we); end
    n_checks++; if (rf_waddr !== 5'd0) begin n_errors++; $display("FAIL reset_init_waddr: got %0d expected 0", rf_waddr); end
    n_checks++; if (rf_wdata !== 32'h0) begin n_errors++; $display("FAIL reset_init_wdata: got %h expected 00000000", rf_wdata); end
    @(posedge clk); #1;
    rst = 1'b1;
    // MEM takes every slot so both MDU results stay queued.
    mem_valid = 1'b1; mem_rd = 5'd1; mem_rd_we = 1'b1; mem_result = 32'h11;
    mdu_valid = 1'b1; mdu_rd = 5'd2; mdu_result = 32'h22;
    @(posedge clk); #1;
    mdu_rd = 5'd3; mdu_result = 32'h33;
    @(posedge clk); #1;
    $display("reset: two MDU entries queued, mdu_ready=%b rf_we=%b", mdu_ready, rf_we);
    n_checks++; if (mdu_ready !== 1'b0) begin n_errors++; $display("FAIL reset_queued_full: got mdu_ready=%b expected 0", mdu_ready); end
    n_checks++; if (rf_we !== 1'b1) begin n_errors++; $display("FAIL reset_pre_we: got %b expected 1", rf_we); end
    set_idle();
    rst = 1'b0;
    #1;
    n_checks++; if (rf_we !== 1'b0) begin n_errors++; $display("FAIL reset_mid_we: got %b expected 0", rf_we); end
    n_checks++; if (rf_waddr !== 5'd0) begin n_errors++; $display("FAIL reset_mid_waddr: got %0d expected 0", rf_waddr); end
    n_checks++; if (rf_wdata !== 32'h0) begin n_errors++; $display("FAIL reset_mid_wdata: got %h expected 00000000", rf_wdata); end
    n_checks++; if (mdu_ready !== 1'b1) begin n_errors++; $display("FAIL reset_mid_mdu_ready: got %b expected 1", mdu_ready); end
    n_checks++; if (mem_ready !== 1'b1) begin n_errors++; $display("FAIL reset_mid_mem_ready: got %b expected 1", mem_ready); end
    exp_retire = 64'd0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      $display("reset: post-release cycle %0d rf_we=%b", i, rf_we);
      n_checks++; if (rf_we !== 1'b0) begin n_errors++; $display("FAIL reset_post_we[%0d]: got %b expected 0", i, rf_we); end
    end
`ifdef RVX_WB_RETIRE_CNT_EN
    n_checks++; if (retire_cnt !== exp_retire) begin n_errors++; $display("FAIL reset_retire: got %0d expected %0d", retire_cnt, exp_retire); end
`endif
  endtask

  task automatic test_load;
    for (int i = 0; i < 8; i++) begin
      set_idle();
      mem_valid = 1'b1; mem_rd_we = 1'b1; mem_is_load = 1'b1;
      mem_rd = 5'(i + 1); mem_funct3 = ld_f3[i]; mem_addr_lo = ld_lo[i];
      mem_load_raw = 32'h80FF_7F01; mem_result = 32'h5555_5555;
      @(posedge clk); #1;
      exp_retire = exp_retire + 64'd1;
      $display("load: f3=%b lo=%0d -> we=%b waddr=%0d wdata=%h", ld_f3[i], ld_lo[i], rf_we, rf_waddr, rf_wdata);
      n_checks++; if (rf_we !== 1'b1) begin n_errors++; $display("FAIL load_we[%0d]: got %b expected 1", i, rf_we); end
      n_checks++; if (rf_waddr !== 5'(i + 1)) begin n_errors++; $display("FAIL load_waddr[%0d]: got %0d expected %0d", i, rf_waddr, i + 1); end
      n_checks++; if (rf_wdata !== ld_exp[i]) begin n_errors++; $display("FAIL load_wdata[%0d]: got %h expected %h", i, rf_wdata, ld_exp[i]); end
    end
    set_idle();
    @(posedge clk); #1;
    n_checks++; if (rf_we !== 1'b0) begin n_errors++; $display("FAIL load_idle_we: got %b expected 0", rf_we); end
    n_checks++; if (rf_wdata !== 32'hFFFF_80FF) begin n_errors++; $display("FAIL load_idle_hold: got %h expected ffff80ff", rf_wdata); end
`ifdef RVX_WB_RETIRE_CNT_EN
    n_checks++; if (retire_cnt !== exp_retire) begin n_errors++; $display("FAIL load_retire: got %0d expected %0d", retire_cnt, exp_retire); end
`endif
  endtask

  task automatic test_back_to_back;
    int mem_sent = 0;
    int mdu_sent = 0;
    logic mem_fire;
    logic mdu_fire;
    logic exp_we;
    for (int c = 0; c < 10; c++) begin
      set_idle();
      mem_valid = (mem_sent < 6); mem_rd_we = 1'b1;
      mem_rd = 5'(10 + mem_sent); mem_result = 32'h100 + 32'(mem_sent);
      mdu_valid = (mdu_sent < 3);
      mdu_rd = 5'(5 + mdu_sent); mdu_result = 32'hA00 + 32'(mdu_sent);
      mem_fire = mem_valid && mem_ready;
      mdu_fire = mdu_valid && mdu_ready;
      @(posedge clk); #1;
      if (mem_fire) mem_sent++;
      if (mdu_fire) mdu_sent++;
      exp_we = (bb_addr[c] != 5'd0);
      $display("b2b: cycle %0d we=%b waddr=%0d wdata=%h mem_ready=%b mdu_ready=%b", c, rf_we, rf_waddr, rf_wdata, mem_ready, mdu_ready);
      n_checks++; if (rf_we !== exp_we) begin n_errors++; $display("FAIL b2b_we[%0d]: got %b expected %b", c, rf_we, exp_we); end
      if (exp_we) begin
        n_checks++; if (rf_waddr !== bb_addr[c]) begin n_errors++; $display("FAIL b2b_waddr[%0d]: got %0d expected %0d", c, rf_waddr, bb_addr[c]); end
        n_checks++; if (rf_wdata !== bb_data[c]) begin n_errors++; $display("FAIL b2b_wdata[%0d]: got %h expected %h", c, rf_wdata, bb_data[c]); end
      end
      if (c == 1 || c == 3) begin
        n_checks++; if (mdu_ready !== 1'b0) begin n_errors++; $display("FAIL b2b_mdu_ready_full[%0d]: got %b expected 0", c, mdu_ready); end
        n_checks++; if (mem_ready !== 1'b0) begin n_errors++; $display("FAIL b2b_mem_ready_full[%0d]: got %b expected 0", c, mem_ready); end
      end
    end
    exp_retire = exp_retire + 64'd6;
    set_idle();
`ifdef RVX_WB_RETIRE_CNT_EN
    n_checks++; if (retire_cnt !== exp_retire) begin n_errors++; $display("FAIL b2b_retire: got %0d expected %0d", retire_cnt, exp_retire); end
`endif
  endtask

  task automatic test_rd_zero;
    set_idle();
    mem_valid = 1'b1; mem_rd = 5'd0; mem_rd_we = 1'b1; mem_result = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    $display("rd0: we=%b waddr=%0d wdata=%h", rf_we, rf_waddr, rf_wdata);
    n_checks++; if (rf_we !== 1'b0) begin n_errors++; $display("FAIL rd0_we: got %b expected 0", rf_we); end
    n_checks++; if (rf_wdata !== 32'h0000_0A02) begin n_errors++; $display("FAIL rd0_wdata_hold: got %h expected 00000a02", rf_wdata); end
    mem_rd = 5'd4; mem_rd_we = 1'b0; mem_result = 32'h44;
    @(posedge clk); #1;
    $display("nowe: we=%b waddr=%0d wdata=%h", rf_we, rf_waddr, rf_wdata);
    n_checks++; if (rf_we !== 1'b0) begin n_errors++; $display("FAIL nowe_we: got %b expected 0", rf_we); end
    n_checks++; if (rf_waddr !== 5'd7) begin n_errors++; $display("FAIL nowe_waddr_hold: got %0d expected 7", rf_waddr); end
    exp_retire = exp_retire + 64'd2;
    set_idle();
`ifdef RVX_WB_RETIRE_CNT_EN
    n_checks++; if (retire_cnt !== exp_retire) begin n_errors++; $display("FAIL rd0_retire: got %0d expected %0d", retire_cnt, exp_retire); end
`endif
  endtask

  task automatic test_mdu_idle;
    set_idle();
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_result = 32'h1234;
    @(posedge clk); #1;
    set_idle();
    $display("mdu: push cycle we=%b", rf_we);
    n_checks++; if (rf_we !== 1'b0) begin n_errors++; $display("FAIL mdu_no_comb_path: got we=%b expected 0", rf_we); end
    @(posedge clk); #1;
    $display("mdu: pop cycle we=%b waddr=%0d wdata=%h", rf_we, rf_waddr, rf_wdata);
    n_checks++; if (rf_we !== 1'b1) begin n_errors++; $display("FAIL mdu_we: got %b expected 1", rf_we); end
    n_checks++; if (rf_waddr !== 5'd9) begin n_errors++; $display("FAIL mdu_waddr: got %0d expected 9", rf_waddr); end
    n_checks++; if (rf_wdata !== 32'h1234) begin n_errors++; $display("FAIL mdu_wdata: got %h expected 00001234", rf_wdata); end
    @(posedge clk); #1;
    n_checks++; if (rf_we !== 1'b0) begin n_errors++; $display("FAIL mdu_after_we: got %b expected 0", rf_we); end
`ifdef RVX_WB_RETIRE_CNT_EN
    n_checks++; if (retire_cnt !== exp_retire) begin n_errors++; $display("FAIL mdu_retire: got %0d expected %0d", retire_cnt, exp_retire); end
`endif
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_rd_zero();
    test_mdu_idle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
